// File: rtl/fpu_multiply_iterative.sv
// Sequential single-precision multiplier: classify, add exponents, radix-2 shift-add
// significand product, then normalize into the shared pre-rounding field format.
module fpu_multiply_iterative #(
    parameter int unsigned ITERATIONS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exponent,
    output logic [23:0] out_mantissa,
    output logic [2:0]  out_guard,
    output logic        out_nan,
    output logic        out_inf,
    output logic        out_zero,
    output logic [2:0]  out_mode
);

    typedef enum logic [1:0] {
        IDLE,
        ITERATE,
        NORMALIZE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [2:0]         mode_q, mode_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        mcand_q, mcand_d;
    logic [23:0]        mplier_q, mplier_d;
    logic [47:0]        prod_q, prod_d;
    logic [4:0]         step_q, step_d;
    logic [7:0]         res_exp_q, res_exp_d;
    logic [23:0]        res_mant_q, res_mant_d;
    logic [2:0]         res_guard_q, res_guard_d;
    logic               res_nan_q, res_nan_d;
    logic               res_inf_q, res_inf_d;
    logic               res_zero_q, res_zero_d;

    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic               spec_nan, spec_inf, spec_zero;
    logic [47:0]        prod_v;
    logic [23:0]        mplier_v;
    logic [24:0]        sum_v;
    logic [5:0]         step_next;
    logic signed [9:0]  exp_n;

    always_comb begin
        a_zero    = (in_a[30:23] == 8'd0);
        a_inf     = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
        a_nan     = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
        b_zero    = (in_b[30:23] == 8'd0);
        b_inf     = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
        b_nan     = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
        spec_nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
        spec_inf  = a_inf || b_inf;
        spec_zero = a_zero || b_zero;
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mode_d      = mode_q;
        exp_d       = exp_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        step_d      = step_q;
        res_exp_d   = res_exp_q;
        res_mant_d  = res_mant_q;
        res_guard_d = res_guard_q;
        res_nan_d   = res_nan_q;
        res_inf_d   = res_inf_q;
        res_zero_d  = res_zero_q;
        prod_v      = prod_q;
        mplier_v    = mplier_q;
        sum_v       = '0;
        step_next   = {1'b0, step_q} + 6'(ITERATIONS_PER_CYCLE);
        exp_n       = exp_q + (prod_q[47] ? 10'sd1 : 10'sd0);
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d      = in_a[31] ^ in_b[31];
                    mode_d      = in_mode;
                    exp_d       = $signed({2'b00, in_a[30:23]}) + $signed({2'b00, in_b[30:23]}) - 10'sd127;
                    mcand_d     = {1'b1, in_a[22:0]};
                    mplier_d    = {1'b1, in_b[22:0]};
                    prod_d      = '0;
                    step_d      = '0;
                    res_exp_d   = '0;
                    res_mant_d  = '0;
                    res_guard_d = '0;
                    res_nan_d   = 1'b0;
                    res_inf_d   = 1'b0;
                    res_zero_d  = 1'b0;
                    state_d     = ITERATE;
                    if (spec_nan) begin
                        res_nan_d  = 1'b1;
                        res_exp_d  = 8'hFF;
                        res_mant_d = 24'hC00000;
                        state_d    = DONE;
                    end else if (spec_inf) begin
                        res_inf_d = 1'b1;
                        res_exp_d = 8'hFF;
                        state_d   = DONE;
                    end else if (spec_zero) begin
                        res_zero_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            ITERATE: begin
                // Carry out of the partial-sum add lands in P[47] as part of the right shift.
                for (int unsigned i = 0; i < ITERATIONS_PER_CYCLE; i++) begin
                    sum_v    = {1'b0, prod_v[47:24]} + (mplier_v[0] ? {1'b0, mcand_q} : 25'd0);
                    prod_v   = {sum_v, prod_v[23:1]};
                    mplier_v = mplier_v >> 1;
                end
                prod_d   = prod_v;
                mplier_d = mplier_v;
                step_d   = step_next[4:0];
                if (step_next >= 6'd24) begin
                    state_d = NORMALIZE;
                end
            end
            NORMALIZE: begin
                exp_d = exp_n;
                if (prod_q[47]) begin
                    res_mant_d  = prod_q[47:24];
                    res_guard_d = {prod_q[23], prod_q[22], |prod_q[21:0]};
                end else begin
                    res_mant_d  = prod_q[46:23];
                    res_guard_d = {prod_q[22], prod_q[21], |prod_q[20:0]};
                end
                res_exp_d = exp_n[7:0];
                if (exp_n >= 10'sd255) begin
                    res_inf_d   = 1'b1;
                    res_exp_d   = 8'hFF;
                    res_mant_d  = '0;
                    res_guard_d = '0;
                end else if (exp_n <= 10'sd0) begin
                    res_zero_d  = 1'b1;
                    res_exp_d   = '0;
                    res_mant_d  = '0;
                    res_guard_d = '0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mode_q      <= '0;
            exp_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            step_q      <= '0;
            res_exp_q   <= '0;
            res_mant_q  <= '0;
            res_guard_q <= '0;
            res_nan_q   <= 1'b0;
            res_inf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mode_q      <= mode_d;
            exp_q       <= exp_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            step_q      <= step_d;
            res_exp_q   <= res_exp_d;
            res_mant_q  <= res_mant_d;
            res_guard_q <= res_guard_d;
            res_nan_q   <= res_nan_d;
            res_inf_q   <= res_inf_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign out_sign     = sign_q;
    assign out_exponent = res_exp_q;
    assign out_mantissa = res_mant_q;
    assign out_guard    = res_guard_q;
    assign out_nan      = res_nan_q;
    assign out_inf      = res_inf_q;
    assign out_zero     = res_zero_q;
    assign out_mode     = mode_q;

endmodule

// File: doc/fpu_multiply_iterative.md
# fpu_multiply_iterative

Sequential single-precision floating-point multiplier. It classifies both operands, adds exponents, and forms the 48-bit significand product with a radix-2 shift-and-add loop. It then normalizes the product to a 24-bit mantissa plus 3 guard bits. Results are emitted in the same pre-rounding field format the divide path produces, so both units feed the shared rounding stage. It sits beside the iterative divider in the FPU execute cluster, behind a valid/ready handshake on each side.

## Interface
- ITERATIONS_PER_CYCLE, 1, shift-add steps per ITERATE cycle; must be one of 1, 2, 3, 4, 6, 8, 12, 24.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept a request
- in_a  in  32  IEEE-754 single operand A
- in_b  in  32  IEEE-754 single operand B
- in_mode  in  3  rounding mode (fpu_round_mode_t), passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_sign  out  1  result sign
- out_exponent  out  8  biased result exponent
- out_mantissa  out  24  normalized significand with the hidden bit at [23]
- out_guard  out  3  {guard, round, sticky}
- out_nan, out_inf, out_zero  out  1 each  special-result flags
- out_mode  out  3  registered copy of in_mode

## Operation
- States: IDLE, ITERATE, NORMALIZE, DONE. `in_ready` is 1 exactly when the state is IDLE.
- Accept in IDLE when `in_valid && in_ready`. On accept, register the operands, the mode, and `sign = a.s ^ b.s`.
- Operand classification:
  - zero: exponent == 0; denormals are flushed to zero and their mantissa is ignored.
  - inf: exponent == 255 and mantissa == 0.
  - nan: exponent == 255 and mantissa != 0.
- Special results use priority nan > inf > zero:
  - nan if either operand is nan, or the operation is inf×zero.
  - Otherwise inf if either operand is inf.
  - Otherwise zero if either operand is zero.
  - A special result goes IDLE→DONE directly.
  - Special encodings: nan → exponent 255, mantissa 0xC00000; inf → exponent 255, mantissa 0; zero → exponent 0, mantissa 0; guard is 0 in all three.
  - The sign is always a.s ^ b.s, including for nan.
- Exponent arithmetic: `e = ea + eb - 127`, computed as a 10-bit signed value.
- Multiply loop:
  - Multiplicand M = {1, ma} (24 bits). Multiplier Q = {1, mb} (24 bits). Accumulator P is 48 bits plus 1 carry bit, cleared on accept.
  - Each step: if Q[0], then {carry, P[47:24]} = P[47:24] + M. Then {carry, P} shifts right 1 and Q shifts right 1.
  - A step counter runs 0..23. ITERATE performs ITERATIONS_PER_CYCLE steps per cycle and exits to NORMALIZE after step 23.
  - After the loop, P = {1, ma} × {1, mb}, which lies in [2^46, 2^48).
- NORMALIZE:
  - If P[47]: mantissa = P[47:24], guard = {P[23], P[22], |P[21:0]}, and e += 1.
  - Else: mantissa = P[46:23], guard = {P[22], P[21], |P[20:0]}.
  - If e ≥ 255: the result becomes inf.
  - If e ≤ 0: the result becomes zero (no denormal output).
  - Otherwise out_exponent = e[7:0].
  - Go to DONE.
- DONE: `out_valid` = 1. On `out_valid && out_ready`, go to IDLE.

## Timing
- Reset (async assert):
  - State returns to IDLE, so in_ready = 1 during and after reset.
  - out_valid = 0.
  - All out_* data and flags = 0, and all internal registers are cleared.
  - Reset mid-operation discards the operation with no output.
- Latency from the accept edge to out_valid high is 1 + 24/ITERATIONS_PER_CYCLE + 1 cycles:
  - 26 cycles with the default ITERATIONS_PER_CYCLE of 1.
  - Special results: 1 cycle (IDLE→DONE).
- While `out_valid && !out_ready`, all out_* signals hold stable and in_ready stays 0.
- in_ready returns to 1 the cycle after the output handshake. A new request cannot be accepted in the same cycle as the output handshake.
- Throughput: one operation per latency + 1 cycles.
- in_a, in_b and in_mode are sampled only on the accept edge. Changes at any other time are ignored.

## Test plan
- 2.0×3.0: in_a=0x40000000, in_b=0x40400000 → sign 0, exponent 0x81, mantissa 0xC00000, guard 0. out_valid exactly 26 cycles after accept.
- 1.5×1.5: in_a=in_b=0x3FC00000 → exponent 0x80, mantissa 0x900000, guard 0 (P[47] path). Repeat with ITERATIONS_PER_CYCLE=4 → same result, out_valid 8 cycles after accept.
- Sticky: in_a=in_b=0x3F800001 → exponent 0x7F, mantissa 0x800002, guard 3'b001.
- Specials:
  - 0x7F800000×0x00000000 → out_nan=1, exponent 0xFF, mantissa 0xC00000.
  - 0xFF800000×0x40000000 → out_inf=1, sign 1.
  - Both results are valid 1 cycle after accept.
- Range:
  - 0x7F000000×0x7F000000 → out_inf=1, exponent 0xFF.
  - 0x00800000×0x00800000 → out_zero=1, exponent 0, mantissa 0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0. Raise out_ready → in_ready=1 on the next cycle.
  - Assert rst in ITERATE step 10 → out_valid=0 and in_ready=1 immediately. After release, a new request completes normally.
